// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS DAC output path.
//   DAC_FRAME_W   : width of one MCP4921-style SPI write
//   CFG_*_BIT     : positions of the config bits inside that frame
//   dac_state_e   : frame sequencer states
//   dac_frame()   : packs config nibble and left-justified data into a frame
package dds_pkg;

  localparam int unsigned DAC_FRAME_W = 16;
  localparam int unsigned DAC_DATA_W  = 12;
  localparam int unsigned DAC_CFG_W   = 4;

  localparam int unsigned CFG_AB_BIT     = 15;
  localparam int unsigned CFG_BUF_BIT    = 14;
  localparam int unsigned CFG_GA_N_BIT   = 13;
  localparam int unsigned CFG_SHDN_N_BIT = 12;

  // Channel A, buffered Vref, 1x gain, active output.
  localparam logic [DAC_CFG_W-1:0] DAC_CFG_DEFAULT = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_TAIL,
    ST_LATCH
  } dac_state_e;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(
    input logic [DAC_CFG_W-1:0]  cfg,
    input logic [DAC_DATA_W-1:0] data_lj
  );
    return {cfg, data_lj};
  endfunction

endpackage

// File: rtl/dac_spi_tx_sclk_tick.sv
// Half-period timer for the DAC SPI clock.
//   clk, rst  : system clock, synchronous active-high reset
//   restart_i : reload the counter so the next tick is HALF_DIV cycles away
//   tick_o    : high for one cycle at the end of every HALF_DIV-cycle interval
module sclk_tick #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Down-counter that reloads itself on expiry or on restart.
  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  // tick_q mirrors (cnt_q == 0) one cycle ahead so the output stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC output stage: frames one waveform sample as a 16-bit SPI write
// {CFG, sample left-justified to 12 bits}, MSB first, then pulses LDAC.
//   clk, rst     : system clock, synchronous active-high reset
//   sample       : m-bit waveform word
//   sample_valid : sample present (need not be held)
//   sample_ready : block can accept a sample (IDLE only)
//   spi_sclk     : serial clock, mode 0, idle low
//   spi_cs_n     : chip select, active low
//   spi_mosi     : serial data
//   dac_ldac_n   : DAC latch strobe, active low
//   busy         : frame or latch in progress
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int unsigned          m        = 12,
  parameter int unsigned          HALF_DIV = 2,
  parameter int unsigned          LDAC_W   = 2,
  parameter logic [DAC_CFG_W-1:0] CFG      = DAC_CFG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [m-1:0] sample,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         spi_sclk,
  output logic         spi_cs_n,
  output logic         spi_mosi,
  output logic         dac_ldac_n,
  output logic         busy
);

  localparam int unsigned LW = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;

  dac_state_e             state_q, state_d;
  logic [DAC_FRAME_W-1:0] sr_q, sr_d;
  logic [3:0]             bit_q, bit_d;
  logic                   phase_q, phase_d;   // 0: sclk low half, 1: sclk high half
  logic [LW-1:0]          lat_q, lat_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   ldac_n_q, ldac_n_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   restart_c;
  logic                   tick;
  logic [DAC_DATA_W-1:0]  data_lj_c;
  logic [DAC_FRAME_W-1:0] frame_c;

  assign data_lj_c = DAC_DATA_W'(sample) << (DAC_DATA_W - m);
  assign frame_c   = dac_frame(CFG, data_lj_c);

  sclk_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart_c),
    .tick_o    (tick)
  );

  // Next-state and next-output logic; outputs are computed one cycle early.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    lat_d     = lat_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ldac_n_d  = ldac_n_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    restart_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sample_valid && ready_q) begin
          state_d   = ST_SETUP;
          sr_d      = frame_c;
          bit_d     = 4'd15;
          phase_d   = 1'b0;
          restart_c = 1'b1;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = frame_c[DAC_FRAME_W-1];
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_q == 4'd0) begin
            state_d = ST_TAIL;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            // Falling edge: advance to the next bit.
            bit_d   = bit_q - 4'd1;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            sr_d    = {sr_q[DAC_FRAME_W-2:0], 1'b0};
            mosi_d  = sr_q[DAC_FRAME_W-2];
          end
        end
      end
      ST_TAIL: begin
        if (tick) begin
          state_d  = ST_LATCH;
          cs_n_d   = 1'b1;
          ldac_n_d = 1'b0;
          lat_d    = LW'(LDAC_W - 1);
        end
      end
      ST_LATCH: begin
        if (lat_q == '0) begin
          state_d  = ST_IDLE;
          ldac_n_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also aborts any frame without LDAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      bit_q    <= 4'd15;
      phase_q  <= 1'b0;
      lat_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      lat_q    <= lat_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign sample_ready = ready_q;
  assign spi_sclk     = sclk_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_mosi     = mosi_q;
  assign dac_ldac_n   = ldac_n_q;
  assign busy         = busy_q;

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC output stage for the DDS core. Accepts the m-bit waveform word from the waveform mux through a valid/ready handshake and frames it as a 16-bit MCP4921-style SPI write: config nibble, then left-justified 12-bit data, MSB first. It then pulses LDAC to update the analog output. The block sits directly downstream of the DDS top on the 50 MHz system clock. When `sample_valid` is tied high, it decimates the waveform to the SPI frame rate.

## Interface
- `m`, 12: sample width, legal range 1..12.
- `HALF_DIV`, 2: clk cycles per SCLK half-period (H), ≥1.
- `LDAC_W`, 2: LDAC low-pulse width in clk cycles (W), ≥1.
- `CFG`, 4'b0111: frame bits [15:12] = {A/B, BUF, GA_n, SHDN_n}.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `sample`  in  m  waveform word from mux.
- `sample_valid`  in  1  sample present.
- `sample_ready`  out  1  block can accept a sample.
- `spi_sclk`  out  1  serial clock, idle low (SPI mode 0).
- `spi_cs_n`  out  1  chip select, active low.
- `spi_mosi`  out  1  serial data.
- `dac_ldac_n`  out  1  DAC latch strobe, active low.
- `busy`  out  1  frame or latch in progress.

## Operation
- All outputs registered.
- Reset values: `sample_ready`=1, `spi_cs_n`=1, `dac_ldac_n`=1, `spi_sclk`=0, `spi_mosi`=0, `busy`=0.
- Accept: when `sample_valid & sample_ready & ~rst` at a clk edge, capture frame = {CFG, sample, (12-m) zeros}.
- FSM states: IDLE → SETUP → SHIFT → TAIL → LATCH → IDLE.
- IDLE: `ready`=1, `busy`=0, all bus lines at idle values. On accept, go to SETUP.
- SETUP, H cycles: `cs_n`=0, `sclk`=0, `mosi`=frame[15].
- SHIFT, 32H cycles: bits 15 down to 0. Each bit is H cycles with `sclk`=0, then H cycles with `sclk`=1. `mosi`=frame[i] for the whole bit period. `mosi` changes only on the cycle `sclk` falls, or on SHIFT entry.
- TAIL, H cycles: `sclk`=0, `cs_n`=0, `mosi`=0.
- LATCH, W cycles: `cs_n`=1, `dac_ldac_n`=0. Then go to IDLE.
- `sample_ready`=0 and `busy`=1 in every state except IDLE.
- Samples presented while not ready are ignored, not queued. Upstream need not hold `valid`.
- Reset mid-frame: the next cycle shows reset values and state is IDLE. No LDAC pulse is issued for the aborted frame.
- A shared tick counter counts 0..H-1 and reloads on each state/phase change. A bit counter counts 15..0.

## Timing
- Accept edge = cycle 0.
- `cs_n` low for cycles 1..34H.
- First `sclk` rise at cycle 2H+1.
- Rise for bit i at cycle H+1+(15-i)·2H+H.
- `ldac_n` low for cycles 34H+1..34H+W.
- `sample_ready`=1 at cycle 34H+W+1. This is the earliest next accept.
- Frame period = 34H+W+1 cycles. With defaults that is 71 cycles, giving ≈704 kS/s at 50 MHz.
- `sample_valid` held high therefore gives back-to-back frames with exactly one IDLE cycle between them.

## Structure
- Package `dds_pkg` holds:
  - `DAC_FRAME_W`=16.
  - CFG bit-position constants.
  - The state enum (IDLE/SETUP/SHIFT/TAIL/LATCH).
  - Default CFG value.
- Sub-module `sclk_tick`: parameterised down-counter producing a one-cycle `tick` every HALF_DIV cycles, with a synchronous `restart` input. The FSM and shift register live in `dac_spi_tx`.

## Test plan
- Defaults, sample=0xABC with one-cycle valid:
  - 16 bits captured on `sclk` rising edges = 0x7ABC.
  - `cs_n` low for exactly 68 cycles.
  - `ldac_n` low for cycles 69–70.
  - `ready` high at cycle 71.
- `m`=8, sample=0xA5: captured frame = 0x7A50.
- `valid` tied high with sample=0x000, then 0xFFF:
  - frames 0x7000 and 0x7FFF.
  - exactly one `ready` cycle between them.
  - samples offered while busy never appear.
- `rst` asserted at cycle 20 of a frame:
  - next cycle `cs_n`=1, `sclk`=0, `ldac_n`=1, `ready`=1.
  - no LDAC pulse.
  - a new accept produces a clean full frame.
- `HALF_DIV`=1, `LDAC_W`=1, sample=0x555:
  - SCLK toggles every cycle.
  - frame 0x7555.
  - period 36 cycles.
- `CFG`=4'b1011, sample=0x800: frame 0xB800, `mosi` stable across every `sclk` high phase.
